// File: rtl/serial_demux_rx_pkg.sv
// serial_demux_rx_pkg
//   Shared definitions for the serial frame receiver / channel demultiplexer.
//   state_t   : receiver FSM states (IDLE, ADDR, LEN, DATA, PAR)
//   cnt_width : width of the field bit counter, clog2(max(ch_bits, len_bits)) + 1
//   Build option: PARITY_CHECK_EN (see serial_demux_rx.sv).
package serial_demux_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAR  = 3'd4
  } state_t;

  function automatic int cnt_width(input int ch_bits, input int len_bits);
    return $clog2((ch_bits > len_bits) ? ch_bits : len_bits) + 1;
  endfunction

endpackage

// File: rtl/serial_demux_rx_fsm.sv
// serial_demux_rx_fsm
//   State register, next-state logic and the end-of-frame strobe for the
//   serial frame receiver. Field counting lives in the parent; this block only
//   sees the "last bit of field" qualifiers.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clk_en      bit-rate tick; the FSM advances only when high
//     ser_in      serial line (start-bit detection in IDLE)
//     addr_last   current ADDR tick carries the last channel-id bit
//     len_last    current LEN tick carries the last length bit
//     len_zero    the length assembled by this LEN tick is zero
//     data_last   current DATA tick carries the last payload bit
//     state       current state
//     done        one-clk pulse after the final tick of a frame
//   Build option PARITY_CHECK_EN inserts the PAR state before frame end.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | line idle, waiting for a start bit (ser_in=0)
//   ADDR    | shifting in the channel id, MSB first
//   LEN     | shifting in the payload length, MSB first
//   DATA    | forwarding payload bits to channel ch_id
//   PAR     | sampling the even-parity bit (PARITY_CHECK_EN)
module serial_demux_rx_fsm
  import serial_demux_rx_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clk_en,
  input  logic   ser_in,
  input  logic   addr_last,
  input  logic   len_last,
  input  logic   len_zero,
  input  logic   data_last,
  output state_t state,
  output logic   done
);

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   frame_end;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    frame_end = 1'b0;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: if (!ser_in) state_d = ST_ADDR;
        ST_ADDR: if (addr_last) state_d = ST_LEN;
        ST_LEN: begin
          if (len_last) begin
            if (len_zero) frame_end = 1'b1;
            else          state_d   = ST_DATA;
          end
        end
        ST_DATA: if (data_last) frame_end = 1'b1;
`ifdef PARITY_CHECK_EN
        ST_PAR: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase

      // Without parity the frame closes on its last field bit; with parity
      // one more tick is needed to sample the parity bit.
      if (frame_end) begin
`ifdef PARITY_CHECK_EN
        state_d = ST_PAR;
`else
        state_d = ST_IDLE;
        done_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign state = state_q;
  assign done  = done_q;

endmodule

// File: rtl/serial_demux_rx.sv
// serial_demux_rx
//   Serial frame receiver and 1-to-NCH demultiplexer. Frame: start bit (0),
//   CH_BITS channel id, LEN_BITS length (both MSB first), then LEN payload
//   bits, each forwarded to channel ch_id with a one-clk valid strobe.
//   Parameters: CH_BITS (NCH = 2**CH_BITS channels), LEN_BITS.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clk_en      bit-rate tick from the line sampler
//     ser_in      serial line, idles high
//     ser_out     per-channel payload bit, only bit ch_id nonzero
//     ser_valid   one-hot one-clk strobe qualifying ser_out
//     ch_id       channel id of the current/last frame
//     busy        high whenever the receiver is not IDLE
//     done        one-clk pulse at frame end
//     par_err     parity mismatch pulse coincident with done
//   Build option PARITY_CHECK_EN: a trailing even-parity bit covering
//   id+len+payload is checked; when undefined par_err is tied low.
module serial_demux_rx
  import serial_demux_rx_pkg::*;
#(
  parameter  int CH_BITS  = 2,
  parameter  int LEN_BITS = 4,
  localparam int NCH      = 2 ** CH_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                ser_in,
  output logic [NCH-1:0]      ser_out,
  output logic [NCH-1:0]      ser_valid,
  output logic [CH_BITS-1:0]  ch_id,
  output logic                busy,
  output logic                done,
  output logic                par_err
);

  localparam int CW = cnt_width(CH_BITS, LEN_BITS);

  state_t              state;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CH_BITS-1:0]  ch_id_q, ch_id_d;
  logic [LEN_BITS-1:0] len_rem_q, len_rem_d, len_shift;
  logic [NCH-1:0]      ser_out_q, ser_out_d;
  logic [NCH-1:0]      ser_valid_q, ser_valid_d;
  logic [NCH-1:0]      ch_onehot;
  logic                addr_last, len_last, len_zero, data_last;

  assign len_shift = LEN_BITS'({len_rem_q, ser_in});
  assign addr_last = (cnt_q == CW'(CH_BITS - 1));
  assign len_last  = (cnt_q == CW'(LEN_BITS - 1));
  assign len_zero  = (len_shift == '0);
  // len_rem counts the bits still to come including the current one, so the
  // all-ones length never wraps and lands on 0 with the last payload bit.
  assign data_last = (len_rem_q == LEN_BITS'(1));
  assign ch_onehot = NCH'(1) << ch_id_q;

  serial_demux_rx_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .ser_in    (ser_in),
    .addr_last (addr_last),
    .len_last  (len_last),
    .len_zero  (len_zero),
    .data_last (data_last),
    .state     (state),
    .done      (done)
  );

  always_comb begin
    cnt_d       = cnt_q;
    ch_id_d     = ch_id_q;
    len_rem_d   = len_rem_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = '0;
    if (clk_en) begin
      case (state)
        ST_IDLE: cnt_d = '0;
        ST_ADDR: begin
          ch_id_d = CH_BITS'({ch_id_q, ser_in});
          cnt_d   = addr_last ? '0 : cnt_q + 1'b1;
        end
        ST_LEN: begin
          len_rem_d = len_shift;
          cnt_d     = len_last ? '0 : cnt_q + 1'b1;
        end
        ST_DATA: begin
          ser_out_d   = ch_onehot & {NCH{ser_in}};
          ser_valid_d = ch_onehot;
          len_rem_d   = len_rem_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ch_id_q     <= '0;
      len_rem_q   <= '0;
      ser_out_q   <= '0;
      ser_valid_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ch_id_q     <= ch_id_d;
      len_rem_q   <= len_rem_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_q, par_d, par_err_q, par_err_d;

  // Running XOR over id, length and payload; the PAR tick folds in the
  // received parity bit, so any residual 1 means odd parity.
  always_comb begin
    par_d     = par_q;
    par_err_d = 1'b0;
    if (clk_en) begin
      case (state)
        ST_IDLE:                  par_d     = 1'b0;
        ST_ADDR, ST_LEN, ST_DATA: par_d     = par_q ^ ser_in;
        ST_PAR:                   par_err_d = par_q ^ ser_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ch_id     = ch_id_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_demux_rx.sv
// Bench for serial_demux_rx (CH_BITS=2, LEN_BITS=4). Frames are described at
// field level; the sender predicts, from the frame contents and tick times,
// the cycle each payload strobe, done pulse and busy window must appear.
module tb_serial_demux_rx;
  localparam int CH_BITS  = 2;
  localparam int LEN_BITS = 4;
  localparam int NCH      = 4;

  logic clk = 1'b0;
  logic rst, clk_en, ser_in;
  logic [NCH-1:0] ser_out, ser_valid;
  logic [CH_BITS-1:0] ch_id;
  logic busy, done, par_err;

  serial_demux_rx #(.CH_BITS(CH_BITS), .LEN_BITS(LEN_BITS)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser_in),
    .ser_out(ser_out), .ser_valid(ser_valid), .ch_id(ch_id),
    .busy(busy), .done(done), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int cyc; int ch; logic b; } strobe_t;
  typedef struct packed { int cyc; int ch; logic perr; } done_t;
  strobe_t sq[$];
  done_t   dq[$];
  bit      busy_map[int];
  logic [NCH-1:0] exp_out = '0;

  int n_strobe, n_done, n_perr, last_strobe_cyc, gap;
  logic [15:0] obs_bits;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    n_strobe = 0; n_done = 0; n_perr = 0; obs_bits = '0; gap = 0; last_strobe_cyc = 0;
  endtask

  // Per-cycle compare against the frame-level predictions.
  always @(negedge clk) begin
    logic [NCH-1:0] ev;
    logic ed, ep;
    if (chk_en) begin
      ev = '0; ed = 1'b0; ep = 1'b0;
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        ev = NCH'(1) << sq[0].ch;
        exp_out = ev & {NCH{sq[0].b}};
        void'(sq.pop_front());
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        ed = 1'b1;
        ep = dq[0].perr;
        check("ch_id_at_done", 32'(ch_id), 32'(dq[0].ch));
        void'(dq.pop_front());
      end
      check("ser_valid", 32'(ser_valid), 32'(ev));
      check("ser_out", 32'(ser_out), 32'(exp_out));
      check("done", 32'(done), 32'(ed));
      check("par_err", 32'(par_err), 32'(ep));
      check("busy", 32'(busy), 32'(busy_map.exists(cyc)));
      if (ser_valid != '0) begin
        n_strobe++;
        obs_bits = {obs_bits[14:0], |(ser_out & ser_valid)};
        gap = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
      end
      if (done) n_done++;
      if (par_err) n_perr++;
    end
  end

  // One bit on the line: period-1 disabled cycles (ser_in=0 to prove it is
  // ignored), then one enabled cycle. tcyc is the cycle of the sampling edge.
  task automatic tick(input logic b, input int period, output int tcyc);
    for (int i = 1; i < period; i++) begin
      @(negedge clk); clk_en = 1'b0; ser_in = 1'b0;
    end
    @(negedge clk); clk_en = 1'b1; ser_in = b; tcyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clk_en = 1'b1; ser_in = 1'b1;
    end
  endtask

  task automatic do_abort();
    @(negedge clk);
    #1 rst = 1'b1; clk_en = 1'b0; ser_in = 1'b1;
    sq.delete(); dq.delete(); busy_map.delete(); exp_out = '0;
    #1;
    check("rst_ser_valid", 32'(ser_valid), 0);
    check("rst_ser_out", 32'(ser_out), 0);
    check("rst_ch_id", 32'(ch_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk); #1 rst = 1'b0;
  endtask

  // abort_after > 0: reset is pulsed right after that many payload bits.
  task automatic send_frame(input int ch, input int len, input logic [15:0] pl,
                            input int period, input logic par_flip, input int abort_after);
    int t, t0, nticks;
    logic p;
    strobe_t s;
    done_t d;
    p = 1'b0;
    nticks = 1 + CH_BITS + LEN_BITS + len;
`ifdef PARITY_CHECK_EN
    nticks++;
`endif
    tick(1'b0, period, t0);
    for (int c = t0 + 1; c <= t0 + (nticks - 1) * period; c++) busy_map[c] = 1'b1;
    for (int i = CH_BITS - 1; i >= 0; i--) begin tick(ch[i], period, t); p ^= ch[i]; end
    for (int i = LEN_BITS - 1; i >= 0; i--) begin tick(len[i], period, t); p ^= len[i]; end
    for (int i = 0; i < len; i++) begin
      tick(pl[i], period, t);
      p ^= pl[i];
      s.cyc = t + 1; s.ch = ch; s.b = pl[i];
      sq.push_back(s);
      if (i + 1 == abort_after) begin
        do_abort();
        return;
      end
    end
`ifdef PARITY_CHECK_EN
    tick(p ^ par_flip, period, t);
    d.perr = par_flip;
`else
    d.perr = 1'b0;
`endif
    d.cyc = t + 1; d.ch = ch;
    dq.push_back(d);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; ser_in = 1'b1;
    clear_obs();
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_ser_out", 32'(ser_out), 0);
    check("reset_ser_valid", 32'(ser_valid), 0);
    check("reset_ch_id", 32'(ch_id), 0);
    check("reset_busy", 32'(busy), 0);
    @(negedge clk); #1 rst = 1'b0;
    idle(2);

    // 1: ch 2, len 3, payload 1,0,1
    clear_obs();
    send_frame(2, 3, 16'h0005, 1, 1'b0, 0);
    idle(3);
    check("t1_strobes", n_strobe, 3);
    check("t1_bits", 32'(obs_bits[2:0]), 32'b101);
    check("t1_done", n_done, 1);
    check("t1_ch_id_hold", 32'(ch_id), 2);

    // 2: ch 1, zero length
    clear_obs();
    send_frame(1, 0, 16'h0000, 1, 1'b0, 0);
    idle(3);
    check("t2_strobes", n_strobe, 0);
    check("t2_done", n_done, 1);
    check("t2_busy_after", 32'(busy), 0);

    // 3: test 1 with clk_en high one clk in four
    clear_obs();
    send_frame(2, 3, 16'h0005, 4, 1'b0, 0);
    idle(3);
    check("t3_strobes", n_strobe, 3);
    check("t3_bits", 32'(obs_bits[2:0]), 32'b101);
    check("t3_gap", gap, 4);

    // 4: reset after second payload bit, then a clean frame
    clear_obs();
    send_frame(2, 3, 16'h0005, 1, 1'b0, 2);
    idle(2);
    clear_obs();
    send_frame(1, 4, 16'h000D, 1, 1'b0, 0);
    idle(3);
    check("t4_strobes", n_strobe, 4);
    check("t4_bits", 32'(obs_bits[3:0]), 32'b1011);
    check("t4_done", n_done, 1);

    // 5: back-to-back frames
    clear_obs();
    send_frame(3, 2, 16'h0002, 1, 1'b0, 0);
    send_frame(0, 1, 16'h0001, 1, 1'b0, 0);
    idle(3);
    check("t5_done", n_done, 2);
    check("t5_strobes", n_strobe, 3);
    check("t5_bits", 32'(obs_bits[2:0]), 32'b011);
    check("t5_ch_id", 32'(ch_id), 0);

    // max length
    clear_obs();
    send_frame(0, 15, 16'h7A5C, 1, 1'b0, 0);
    idle(3);
    check("max_strobes", n_strobe, 15);
    check("max_done", n_done, 1);

`ifdef PARITY_CHECK_EN
    // 6: id 10, len 0011, payload 101 has five ones: parity bit 1 is good.
    clear_obs();
    send_frame(2, 3, 16'h0005, 1, 1'b0, 0);
    send_frame(2, 3, 16'h0005, 1, 1'b1, 0);
    idle(3);
    check("t6_done", n_done, 2);
    check("t6_perr", n_perr, 1);
`endif

    check("strobe_queue_empty", sq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
